// File: rtl/axi_arb_pkg.sv
// Shared helpers for the AXI read/write arbiters: field widths of the SELF
// address and data buses, the clog2 helper, and slice offsets into the
// flattened per-port request vectors.
package axi_arb_pkg;

  localparam int unsigned LenWidth  = 8;
  localparam int unsigned RespWidth = 2;

  // Ceiling log2 with a floor of 1, so a single-entry index still has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

  // AR bus payload: {addr, len, id}.
  function automatic int unsigned ar_bus_width(input int unsigned addr_w,
                                               input int unsigned id_w);
    return addr_w + LenWidth + id_w;
  endfunction

  // R bus payload: {data, resp, last, id}.
  function automatic int unsigned r_bus_width(input int unsigned data_w,
                                              input int unsigned id_w);
    return data_w + RespWidth + 1 + id_w;
  endfunction

  // LSB of port's address field inside the flattened reqAddr vector.
  function automatic int unsigned addr_lsb(input int unsigned port,
                                           input int unsigned addr_w);
    return port * addr_w;
  endfunction

  // LSB of port's length field inside the flattened reqLen vector.
  function automatic int unsigned len_lsb(input int unsigned port);
    return port * LenWidth;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible      : per-port request qualifiers
//   ptr           : highest-priority port index this cycle
//   en            : when low no grant is issued
//   grant_c       : one-hot grant
//   grant_idx_c   : encoded index of the granted port
//   grant_valid_c : a grant was issued
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = clog2(NumPorts)
) (
  input  logic [NumPorts-1:0] eligible,
  input  logic [IdxWidth-1:0] ptr,
  input  logic                en,
  output logic [NumPorts-1:0] grant_c,
  output logic [IdxWidth-1:0] grant_idx_c,
  output logic                grant_valid_c
);

  // Scan from ptr upward with wrap; first eligible port wins.
  always_comb begin
    int unsigned cand;
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = 0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NumPorts) cand = cand - NumPorts;
      if (en && !grant_valid_c && eligible[IdxWidth'(cand)]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = IdxWidth'(cand);
      end
    end
    if (grant_valid_c) grant_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read address/data channel pair among NumPorts requesters.
// AR requests are arbitrated round-robin into a single output register and
// tagged with the port index as AXI ID; R beats are steered back by ID.
// Per-port outstanding-burst counters throttle requesters and drive idle.
//   ap_clk / kernel_reset            : clock, synchronous active-high reset
//   reqAddr* / reqLen                : per-port AR request side (SELF)
//   reqData* / reqResp / reqLast     : per-port R return side (SELF)
//   axiReadAddr* / axiReadLen / Id   : master AR side
//   axiReadData* / Resp / Last / Id  : master R side
//   idle                             : nothing pending or in flight
//   errFlag                          : sticky unknown-ID / underflow error
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                          ap_clk,
  input  logic                          kernel_reset,
  input  logic [NumPorts-1:0]           reqAddrValid,
  input  logic [NumPorts*AddrWidth-1:0] reqAddr,
  input  logic [NumPorts*LenWidth-1:0]  reqLen,
  output logic [NumPorts-1:0]           reqAddrStop,
  output logic [NumPorts-1:0]           reqDataValid,
  output logic [DataWidth-1:0]          reqData,
  output logic [RespWidth-1:0]          reqResp,
  output logic                          reqLast,
  input  logic [NumPorts-1:0]           reqDataStop,
  output logic                          axiReadAddrValid,
  output logic [AddrWidth-1:0]          axiReadAddr,
  output logic [LenWidth-1:0]           axiReadLen,
  output logic [IdWidth-1:0]            axiReadId,
  input  logic                          axiReadAddrStop,
  input  logic                          axiReadDataValid,
  input  logic [DataWidth-1:0]          axiReadData,
  input  logic [RespWidth-1:0]          axiReadResp,
  input  logic                          axiReadLast,
  input  logic [IdWidth-1:0]            axiReadDataId,
  output logic                          axiReadDataStop,
  output logic                          idle,
  output logic                          errFlag
);

  localparam int unsigned IdxWidth   = clog2(NumPorts);
  localparam int unsigned CntWidth   = clog2(MaxOutstanding + 1);
  localparam int unsigned ArBusWidth = ar_bus_width(AddrWidth, IdWidth);

  logic                  out_valid_q, out_valid_d;
  logic [ArBusWidth-1:0] ar_q, ar_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]   cnt_q [NumPorts];
  logic [CntWidth-1:0]   cnt_d [NumPorts];
  logic                  err_q, err_d;

  logic                  load_en_c;
  logic [NumPorts-1:0]   eligible_c;
  logic [NumPorts-1:0]   grant_c;
  logic [IdxWidth-1:0]   grant_idx_c;
  logic                  grant_valid_c;
  logic [AddrWidth-1:0]  sel_addr_c;
  logic [LenWidth-1:0]   sel_len_c;
  logic                  id_known_c;
  logic [IdxWidth-1:0]   rd_idx_c;
  logic                  r_last_xfer_c;

  // Output register may take a new request when empty or draining this cycle.
  assign load_en_c = !out_valid_q || !axiReadAddrStop;

  // A port is eligible only while it has headroom for another burst.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      eligible_c[IdxWidth'(i)] = reqAddrValid[IdxWidth'(i)] &&
                                 (cnt_q[IdxWidth'(i)] < CntWidth'(MaxOutstanding));
    end
  end

  rr_arbiter #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_rr_arbiter (
    .eligible      (eligible_c),
    .ptr           (rr_ptr_q),
    .en            (load_en_c && !kernel_reset),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  assign reqAddrStop = ~grant_c;

  // Payload mux for the granted port.
  always_comb begin
    sel_addr_c = '0;
    sel_len_c  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (grant_c[IdxWidth'(i)]) begin
        sel_addr_c = reqAddr[addr_lsb(i, AddrWidth) +: AddrWidth];
        sel_len_c  = reqLen[len_lsb(i) +: LenWidth];
      end
    end
  end

  // AR output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    ar_d        = ar_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en_c) begin
      out_valid_d = grant_valid_c;
      if (grant_valid_c) begin
        ar_d = {sel_addr_c, sel_len_c, IdWidth'(grant_idx_c)};
      end
    end
    if (grant_valid_c) begin
      rr_ptr_d = (32'(grant_idx_c) == NumPorts - 1) ? '0 : grant_idx_c + IdxWidth'(1);
    end
  end

  assign axiReadAddrValid = out_valid_q;
  assign axiReadAddr      = ar_q[ArBusWidth-1 -: AddrWidth];
  assign axiReadLen       = ar_q[IdWidth +: LenWidth];
  assign axiReadId        = ar_q[IdWidth-1:0];

  // R steering: beats with an out-of-range ID are swallowed.
  assign id_known_c = 32'(axiReadDataId) < NumPorts;
  assign rd_idx_c   = IdxWidth'(axiReadDataId);

  always_comb begin
    reqDataValid = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      reqDataValid[IdxWidth'(i)] = axiReadDataValid && (32'(axiReadDataId) == i);
    end
  end

  assign axiReadDataStop = id_known_c ? reqDataStop[rd_idx_c] : 1'b0;
  assign reqData         = axiReadData;
  assign reqResp         = axiReadResp;
  assign reqLast         = axiReadLast;

  assign r_last_xfer_c = axiReadDataValid && !axiReadDataStop && axiReadLast;

  // Outstanding counters; a completion on an empty counter is an error and
  // is dropped, while a same-cycle grant still counts.
  always_comb begin
    logic dec;
    err_d = err_q;
    dec   = 1'b0;
    if (axiReadDataValid && !id_known_c) err_d = 1'b1;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      dec = r_last_xfer_c && id_known_c && (rd_idx_c == IdxWidth'(i));
      cnt_d[IdxWidth'(i)] = cnt_q[IdxWidth'(i)];
      if (dec && (cnt_q[IdxWidth'(i)] == '0)) begin
        err_d = 1'b1;
        if (grant_c[IdxWidth'(i)]) cnt_d[IdxWidth'(i)] = CntWidth'(1);
      end else if (grant_c[IdxWidth'(i)] && !dec) begin
        cnt_d[IdxWidth'(i)] = cnt_q[IdxWidth'(i)] + CntWidth'(1);
      end else if (dec && !grant_c[IdxWidth'(i)]) begin
        cnt_d[IdxWidth'(i)] = cnt_q[IdxWidth'(i)] - CntWidth'(1);
      end
    end
  end

  always_comb begin
    idle = !out_valid_q;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (cnt_q[IdxWidth'(i)] != '0) idle = 1'b0;
    end
  end

  assign errFlag = err_q;

  always_ff @(posedge ap_clk) begin
    if (kernel_reset) begin
      out_valid_q <= 1'b0;
      ar_q        <= '0;
      rr_ptr_q    <= '0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < NumPorts; i++) cnt_q[IdxWidth'(i)] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ar_q        <= ar_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < NumPorts; i++) cnt_q[IdxWidth'(i)] <= cnt_d[IdxWidth'(i)];
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter (4 ports, 2 outstanding bursts per port).
module tb_axi_read_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*8-1:0]   req_len;
  logic [NP-1:0]     req_stop;
  logic [NP-1:0]     rd_valid;
  logic [DW-1:0]     rd_data;
  logic [1:0]        rd_resp;
  logic              rd_last;
  logic [NP-1:0]     req_data_stop;
  logic              ar_valid;
  logic [AW-1:0]     ar_addr;
  logic [7:0]        ar_len;
  logic [IW-1:0]     ar_id;
  logic              ar_stop;
  logic              r_valid;
  logic [DW-1:0]     r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [IW-1:0]     r_id;
  logic              r_stop;
  logic              idle;
  logic              err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .NumPorts       (NP),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .IdWidth        (IW),
    .MaxOutstanding (2)
  ) dut (
    .ap_clk           (clk),
    .kernel_reset     (rst),
    .reqAddrValid     (req_valid),
    .reqAddr          (req_addr),
    .reqLen           (req_len),
    .reqAddrStop      (req_stop),
    .reqDataValid     (rd_valid),
    .reqData          (rd_data),
    .reqResp          (rd_resp),
    .reqLast          (rd_last),
    .reqDataStop      (req_data_stop),
    .axiReadAddrValid (ar_valid),
    .axiReadAddr      (ar_addr),
    .axiReadLen       (ar_len),
    .axiReadId        (ar_id),
    .axiReadAddrStop  (ar_stop),
    .axiReadDataValid (r_valid),
    .axiReadData      (r_data),
    .axiReadResp      (r_resp),
    .axiReadLast      (r_last),
    .axiReadDataId    (r_id),
    .axiReadDataStop  (r_stop),
    .idle             (idle),
    .errFlag          (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp4;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; req_data_stop = '0;
    ar_stop = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0; r_id = '0;
    tick; tick;

    // Reset: no grants, R routing still live, beat must not touch counters.
    req_valid = 4'hF; r_valid = 1'b1; r_id = 4'd1; r_last = 1'b1;
    #1;
    chk("rst_addr_stop", 64'(req_stop), 64'hF);
    chk("rst_r_route", 64'(rd_valid), 64'b0010);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    tick;
    chk("rst_err", 64'(err), 64'd0);

    // Round robin over all four ports.
    rst = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_id = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = 64'h100 * 64'(i + 1);
      req_len[i*8 +: 8]    = 8'(i + 1);
    end
    #1;
    chk("rr_first_stop", 64'(req_stop), 64'b1110);
    chk("rr_latency", 64'(ar_valid), 64'd0);
    chk("rst_beat_cnt1", 64'(dut.cnt_q[1]), 64'd0);
    for (int g = 0; g < 4; g++) begin
      tick;
      exp4 = ~(4'b0001 << ((g + 1) % 4));
      chk("rr_ar_valid", 64'(ar_valid), 64'd1);
      chk("rr_id", 64'(ar_id), 64'(g));
      chk("rr_addr", ar_addr, 64'h100 * 64'(g + 1));
      chk("rr_len", 64'(ar_len), 64'(g + 1));
      chk("rr_next_stop", 64'(req_stop), 64'(exp4));
    end
    chk("rr_cnt3", 64'(dut.cnt_q[3]), 64'd1);
    chk("rr_not_idle", 64'(idle), 64'd0);

    // Reset with bursts outstanding and an AR pending.
    req_valid = '0; ar_stop = 1'b1; rst = 1'b1;
    tick;
    chk("mid_rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    for (int i = 0; i < 4; i++) chk("mid_rst_cnt", 64'(dut.cnt_q[i]), 64'd0);
    rst = 1'b0; ar_stop = 1'b0; r_valid = 1'b1; r_id = 4'd0; r_last = 1'b1;
    #1;
    chk("late_route", 64'(rd_valid), 64'b0001);
    chk("late_rstop", 64'(r_stop), 64'd0);
    tick;
    chk("late_underflow_err", 64'(err), 64'd1);
    chk("late_cnt0", 64'(dut.cnt_q[0]), 64'd0);
    r_valid = 1'b0; r_last = 1'b0; rst = 1'b1;
    tick;
    chk("err_cleared", 64'(err), 64'd0);
    rst = 1'b0;

    // Port 2 alone with the master stalling five cycles.
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 64'h1000; req_len[2*8 +: 8] = 8'd7; ar_stop = 1'b1;
    #1;
    chk("p2_grant_stop", 64'(req_stop), 64'b1011);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("p2_hold_valid", 64'(ar_valid), 64'd1);
      chk("p2_hold_addr", ar_addr, 64'h1000);
      chk("p2_hold_len", 64'(ar_len), 64'd7);
      chk("p2_hold_stop", 64'(req_stop), 64'hF);
    end
    chk("p2_cnt", 64'(dut.cnt_q[2]), 64'd1);
    req_valid = '0; ar_stop = 1'b0;
    tick;
    chk("p2_ar_drained", 64'(ar_valid), 64'd0);
    chk("p2_not_idle", 64'(idle), 64'd0);
    r_valid = 1'b1; r_id = 4'd2; r_last = 1'b1;
    tick;
    r_valid = 1'b0; r_last = 1'b0;
    chk("p2_cnt_done", 64'(dut.cnt_q[2]), 64'd0);
    chk("p2_idle", 64'(idle), 64'd1);

    // Port 1 hits the outstanding limit of 2.
    req_valid = 4'b0010; req_addr[1*AW +: AW] = 64'h2000; req_len[1*8 +: 8] = 8'd3;
    #1;
    chk("lim_first_stop", 64'(req_stop), 64'b1101);
    tick;
    chk("lim_second_stop", 64'(req_stop), 64'b1101);
    chk("lim_cnt1_a", 64'(dut.cnt_q[1]), 64'd1);
    tick;
    chk("lim_full_stop", 64'(req_stop), 64'hF);
    chk("lim_cnt1_b", 64'(dut.cnt_q[1]), 64'd2);
    tick;
    chk("lim_still_stop", 64'(req_stop), 64'hF);
    chk("lim_ar_empty", 64'(ar_valid), 64'd0);
    r_valid = 1'b1; r_id = 4'd1; r_last = 1'b1;
    #1;
    chk("lim_same_cycle_stop", 64'(req_stop), 64'hF);
    chk("lim_route", 64'(rd_valid), 64'b0010);
    tick;
    r_valid = 1'b0; r_last = 1'b0;
    #1;
    chk("lim_release_stop", 64'(req_stop), 64'b1101);
    tick;
    chk("lim_third_valid", 64'(ar_valid), 64'd1);
    chk("lim_third_id", 64'(ar_id), 64'd1);
    chk("lim_third_addr", ar_addr, 64'h2000);
    chk("lim_third_len", 64'(ar_len), 64'd3);
    chk("lim_cnt1_c", 64'(dut.cnt_q[1]), 64'd2);
    req_valid = '0;

    // One burst on port 3, then drain port 1.
    req_valid = 4'b1000;
    tick;
    req_valid = '0;
    chk("p3_id", 64'(ar_id), 64'd3);
    chk("p3_cnt", 64'(dut.cnt_q[3]), 64'd1);
    r_valid = 1'b1; r_id = 4'd1; r_last = 1'b1;
    tick; tick;
    r_valid = 1'b0; r_last = 1'b0;
    chk("p1_drained", 64'(dut.cnt_q[1]), 64'd0);

    // Four-beat burst on ID 3 with backpressure.
    r_valid = 1'b1; r_id = 4'd3; r_data = 64'hA1;
    #1;
    chk("b1_route", 64'(rd_valid), 64'b1000);
    chk("b1_data", rd_data, 64'hA1);
    chk("b1_rstop", 64'(r_stop), 64'd0);
    tick;
    r_data = 64'hA2; req_data_stop = 4'b1000;
    #1;
    chk("b2_rstop", 64'(r_stop), 64'd1);
    chk("b2_route", 64'(rd_valid), 64'b1000);
    tick;
    req_data_stop = '0;
    #1;
    chk("b2_release", 64'(r_stop), 64'd0);
    tick;
    r_data = 64'hA3; r_resp = 2'b10; req_data_stop = 4'b0001;
    #1;
    chk("b3_other_stop", 64'(r_stop), 64'd0);
    chk("b3_resp", 64'(rd_resp), 64'd2);
    chk("b3_cnt", 64'(dut.cnt_q[3]), 64'd1);
    tick;
    r_data = 64'hA4; r_resp = 2'b00; r_last = 1'b1; req_data_stop = 4'b1000;
    #1;
    chk("b4_last", 64'(rd_last), 64'd1);
    tick;
    chk("b4_stalled_cnt", 64'(dut.cnt_q[3]), 64'd1);
    req_data_stop = '0;
    tick;
    r_valid = 1'b0; r_last = 1'b0;
    chk("b4_cnt", 64'(dut.cnt_q[3]), 64'd0);
    chk("b4_idle", 64'(idle), 64'd1);
    chk("b4_err", 64'(err), 64'd0);

    // Unknown ID is discarded and flags an error.
    r_valid = 1'b1; r_id = 4'd5; r_last = 1'b1; req_data_stop = 4'hF;
    #1;
    chk("unk_route", 64'(rd_valid), 64'd0);
    chk("unk_rstop", 64'(r_stop), 64'd0);
    tick;
    r_valid = 1'b0; r_last = 1'b0; req_data_stop = '0;
    chk("unk_err", 64'(err), 64'd1);
    chk("unk_idle", 64'(idle), 64'd1);
    tick; tick;
    chk("unk_err_sticky", 64'(err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
